// File: rtl/rng_lookup_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : rng_lookup_loader_if
//  Purpose  : Load-stream handshake and coefficient read bus of the loader.
//  Revision : 1.0 - initial release
// ============================================================================
interface rng_lookup_loader_if #(
    parameter int BY            = 16,
    parameter int K             = 3,
    parameter int SEC_ADDR_SIZE = 4
);
    logic [7:0]               wr_byte;
    logic                     wr_valid;
    logic                     wr_ready;
    logic                     en;
    logic [SEC_ADDR_SIZE-1:0] section_addr;
    logic [K-1:0]             subsection_addr;
    logic [BY-1:0]            c0;
    logic [BY-1:0]            c1;
    logic                     table_valid;
    logic                     load_done;
    logic                     load_error;

    modport master (
        output wr_byte, wr_valid, en, section_addr, subsection_addr,
        input  wr_ready, c0, c1, table_valid, load_done, load_error
    );

    modport slave (
        input  wr_byte, wr_valid, en, section_addr, subsection_addr,
        output wr_ready, c0, c1, table_valid, load_done, load_error
    );
endinterface
`default_nettype wire

// File: rtl/rng_lookup_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rng_lookup_loader
//  Purpose  : Loads a checksummed coefficient table from a byte stream and
//             serves registered (c0, c1) reads by section/subsection.
//  Revision : 1.0 - initial release
// ============================================================================
module rng_lookup_loader #(
    parameter int BY            = 16,
    parameter int K             = 3,
    parameter int G_OCT         = 4,
    parameter int D_OCT         = 4,
    parameter int SEC_ADDR_SIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    rng_lookup_loader_if.slave bus
);
    localparam int c_N   = (G_OCT + D_OCT) * (2 ** K);
    localparam int c_WB  = BY / 8;
    localparam int c_AW  = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_EW  = $clog2(c_N + 1);
    localparam int c_BW  = (c_WB > 1) ? $clog2(c_WB) : 1;
    localparam int c_RAW = SEC_ADDR_SIZE + K;

    localparam logic [7:0]      c_SYNC      = 8'hA5;
    localparam logic [c_EW-1:0] c_ENTRY_END = c_EW'(c_N);
    localparam logic [c_BW-1:0] c_LAST_BYTE = c_BW'(c_WB - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_CHECK = 2'd2;

    logic [1:0]      r_state;
    logic [c_BW-1:0] r_byte_idx;
    logic            r_coef_sel;
    logic [c_EW-1:0] r_entry;
    logic [7:0]      r_xor;
    logic            r_table_valid;
    logic            r_load_done;
    logic            r_load_error;
    logic [BY-1:0]   r_c0;
    logic [BY-1:0]   r_c1;

    logic [BY-1:0]   r_c0_mem [c_N];
    logic [BY-1:0]   r_c1_mem [c_N];

    logic            w_ready;
    logic            w_accept;
    logic            w_payload_done;
    logic            w_load_byte;
    logic            w_word_end;
    logic            w_sum_ok;
    logic [BY-1:0]   w_word;
    logic [c_AW-1:0] w_widx;
    logic [c_RAW-1:0] w_raddr;
    logic [31:0]     w_raddr_ext;
    logic            w_rd_in_range;
    logic [c_AW-1:0] w_ridx;

    assign w_ready        = (r_state != c_ST_CHECK);
    assign w_accept       = bus.wr_valid & w_ready;
    assign w_payload_done = (r_entry == c_ENTRY_END);
    assign w_load_byte    = w_accept & (r_state == c_ST_LOAD) & ~w_payload_done;
    assign w_word_end     = w_load_byte & (r_byte_idx == c_LAST_BYTE);
    assign w_sum_ok       = (bus.wr_byte == r_xor);
    assign w_widx         = r_entry[c_AW-1:0];

    // Coefficient assembly: earlier bytes of a word are held MSB-first.
    generate
        if (c_WB > 1) begin : g_multi_byte
            logic [BY-9:0] r_shift;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_shift <= '0;
                end else if (w_load_byte) begin
                    r_shift <= w_word[BY-9:0];
                end
            end

            assign w_word = {r_shift, bus.wr_byte};
        end else begin : g_single_byte
            assign w_word = bus.wr_byte;
        end
    endgenerate

    // The checksum verdict is registered on the edge that accepts the
    // checksum byte, so load_done/table_valid/load_error are all visible
    // together during the single CHECK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_byte_idx    <= '0;
            r_coef_sel    <= 1'b0;
            r_entry       <= '0;
            r_xor         <= '0;
            r_table_valid <= 1'b0;
            r_load_done   <= 1'b0;
            r_load_error  <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && (bus.wr_byte == c_SYNC)) begin
                        r_state       <= c_ST_LOAD;
                        r_byte_idx    <= '0;
                        r_coef_sel    <= 1'b0;
                        r_entry       <= '0;
                        r_xor         <= '0;
                        r_table_valid <= 1'b0;
                        r_load_error  <= 1'b0;
                    end
                end
                c_ST_LOAD: begin
                    if (w_accept) begin
                        if (w_payload_done) begin
                            r_state       <= c_ST_CHECK;
                            r_load_done   <= 1'b1;
                            r_table_valid <= w_sum_ok;
                            r_load_error  <= ~w_sum_ok;
                        end else begin
                            r_xor <= r_xor ^ bus.wr_byte;
                            if (r_byte_idx == c_LAST_BYTE) begin
                                r_byte_idx <= '0;
                                r_coef_sel <= ~r_coef_sel;
                                if (r_coef_sel) begin
                                    r_entry <= r_entry + c_EW'(1);
                                end
                            end else begin
                                r_byte_idx <= r_byte_idx + c_BW'(1);
                            end
                        end
                    end
                end
                c_ST_CHECK: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Table storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_word_end) begin
            if (r_coef_sel) begin
                r_c1_mem[w_widx] <= w_word;
            end else begin
                r_c0_mem[w_widx] <= w_word;
            end
        end
    end

    assign w_raddr       = {bus.section_addr, bus.subsection_addr};
    assign w_raddr_ext   = 32'(w_raddr);
    assign w_rd_in_range = (w_raddr_ext < 32'(c_N));
    assign w_ridx        = c_AW'(w_raddr);

    // Read-first: a same-edge write lands after this register samples memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c0 <= '0;
            r_c1 <= '0;
        end else if (bus.en) begin
            if (w_rd_in_range) begin
                r_c0 <= r_c0_mem[w_ridx];
                r_c1 <= r_c1_mem[w_ridx];
            end else begin
                r_c0 <= '0;
                r_c1 <= '0;
            end
        end
    end

    assign bus.wr_ready    = w_ready;
    assign bus.c0          = r_c0;
    assign bus.c1          = r_c1;
    assign bus.table_valid = r_table_valid;
    assign bus.load_done   = r_load_done;
    assign bus.load_error  = r_load_error;
endmodule
`default_nettype wire

// File: tb/tb_rng_lookup_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rng_lookup_loader
//  Purpose  : Self-checking bench for rng_lookup_loader with a read scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rng_lookup_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] m_c0 [64];
    logic [15:0] m_c1 [64];
    logic [31:0] sb_q [$];

    rng_lookup_loader_if #(.BY(16), .K(3), .SEC_ADDR_SIZE(4)) bus ();

    rng_lookup_loader #(
        .BY(16), .K(3), .G_OCT(4), .D_OCT(4), .SEC_ADDR_SIZE(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat_word(input int pat, input int e, input int c);
        logic [15:0] base;
        base = 16'(e * 257);
        if (pat == 0) return (c == 0) ? base : ~base;
        if (e == 3) return (c == 0) ? 16'hA5A5 : 16'h00A5;
        return (c == 0) ? (base ^ 16'h1234) : 16'(e * 16'h0203 + 16'h0055);
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            n = 0;
            while ($urandom_range(1, 0) == 1 && n < 6) begin
                bus.wr_valid = 1'b0;
                @(posedge clk); #1;
                n++;
            end
        end
        bus.wr_byte  = b;
        bus.wr_valid = 1'b1;
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_ready_outside_check: got %b expected 1", bus.wr_ready);
        end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_read(input int sec, input int sub);
        int          idx;
        logic [31:0] exp_v;
        logic [31:0] got_v;
        idx = sec * 8 + sub;
        bus.en              = 1'b1;
        bus.section_addr    = 4'(sec);
        bus.subsection_addr = 3'(sub);
        sb_q.push_back((idx < 64) ? {m_c0[idx], m_c1[idx]} : 32'h0);
        @(posedge clk); #1;
        bus.en = 1'b0;
        exp_v = sb_q.pop_front();
        got_v = {bus.c0, bus.c1};
        n_cmp++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL read[%0d]: got c0c1=%h expected %h", idx, got_v, exp_v);
        end
    endtask

    // Sends sync + payload (+ checksum). stop_after>=0 halts before that payload
    // byte; probe>=0 issues a read of the probed byte's entry on its accept edge.
    task automatic send_frame(input int pat, input bit bad, input bit gaps,
                              input int stop_after, input int probe);
        logic [7:0]  sum;
        logic [7:0]  bv;
        logic [15:0] w;
        logic [31:0] exp_v;
        int          p;
        sum = 8'h00;
        send_byte(8'hA5, gaps);
        for (int e = 0; e < 64; e++) begin
            for (int c = 0; c < 2; c++) begin
                w = pat_word(pat, e, c);
                for (int b = 0; b < 2; b++) begin
                    p = e * 4 + c * 2 + b;
                    if (p == stop_after) return;
                    bv  = (b == 0) ? w[15:8] : w[7:0];
                    sum = sum ^ bv;
                    if (p == probe) begin
                        bus.en              = 1'b1;
                        bus.section_addr    = 4'(e / 8);
                        bus.subsection_addr = 3'(e % 8);
                        sb_q.push_back({m_c0[e], m_c1[e]});
                    end
                    send_byte(bv, gaps && (p != probe));
                    if (p == probe) begin
                        bus.en = 1'b0;
                        exp_v  = sb_q.pop_front();
                        n_cmp++;
                        if ({bus.c0, bus.c1} !== exp_v) begin
                            n_err++;
                            $display("FAIL read_first[%0d]: got c0c1=%h expected %h",
                                     e, {bus.c0, bus.c1}, exp_v);
                        end
                    end
                end
                if (c == 0) m_c0[e] = w;
                else        m_c1[e] = w;
            end
        end
        send_byte(bad ? (sum ^ 8'h01) : sum, gaps);
        n_cmp += 4;
        if (bus.load_done !== 1'b1) begin
            n_err++; $display("FAIL load_done_pulse: got %b expected 1", bus.load_done);
        end
        if (bus.wr_ready !== 1'b0) begin
            n_err++; $display("FAIL ready_in_check: got %b expected 0", bus.wr_ready);
        end
        if (bus.table_valid !== !bad) begin
            n_err++; $display("FAIL table_valid: got %b expected %b", bus.table_valid, !bad);
        end
        if (bus.load_error !== bad) begin
            n_err++; $display("FAIL load_error: got %b expected %b", bus.load_error, bad);
        end
        @(posedge clk); #1;
        n_cmp += 2;
        if (bus.load_done !== 1'b0) begin
            n_err++; $display("FAIL load_done_one_cycle: got %b expected 0", bus.load_done);
        end
        if (bus.wr_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_check: got %b expected 1", bus.wr_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 6;
        if (bus.c0 !== 16'h0)         begin n_err++; $display("FAIL rst_c0: got %h expected 0000", bus.c0); end
        if (bus.c1 !== 16'h0)         begin n_err++; $display("FAIL rst_c1: got %h expected 0000", bus.c1); end
        if (bus.table_valid !== 1'b0) begin n_err++; $display("FAIL rst_table_valid: got %b expected 0", bus.table_valid); end
        if (bus.load_done !== 1'b0)   begin n_err++; $display("FAIL rst_load_done: got %b expected 0", bus.load_done); end
        if (bus.load_error !== 1'b0)  begin n_err++; $display("FAIL rst_load_error: got %b expected 0", bus.load_error); end
        if (bus.wr_ready !== 1'b1)    begin n_err++; $display("FAIL rst_wr_ready: got %b expected 1", bus.wr_ready); end
        rst = 1'b0;
    endtask

    task automatic test_full_frame();
        send_frame(0, 1'b0, 1'b0, -1, -1);
        do_read(2, 5);
        n_cmp += 2;
        if (bus.c0 !== 16'h1515) begin n_err++; $display("FAIL entry21_c0: got %h expected 1515", bus.c0); end
        if (bus.c1 !== 16'hEAEA) begin n_err++; $display("FAIL entry21_c1: got %h expected eaea", bus.c1); end
        do_read(0, 0);
        do_read(7, 7);
        bus.section_addr = 4'd1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.c0, bus.c1} !== {m_c0[63], m_c1[63]}) begin
            n_err++;
            $display("FAIL hold_en0: got %h expected %h", {bus.c0, bus.c1}, {m_c0[63], m_c1[63]});
        end
    endtask

    task automatic test_bad_checksum();
        send_frame(0, 1'b1, 1'b0, -1, -1);
        do_read(2, 5);
    endtask

    task automatic test_sync_hunt();
        send_byte(8'h00, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hFF, 1'b0);
        n_cmp += 3;
        if (bus.load_error !== 1'b1)  begin n_err++; $display("FAIL junk_load_error: got %b expected 1", bus.load_error); end
        if (bus.table_valid !== 1'b0) begin n_err++; $display("FAIL junk_table_valid: got %b expected 0", bus.table_valid); end
        if (bus.load_done !== 1'b0)   begin n_err++; $display("FAIL junk_load_done: got %b expected 0", bus.load_done); end
        do_read(0, 0);
        send_frame(1, 1'b0, 1'b0, -1, 31);
        do_read(0, 3);
        n_cmp++;
        if (bus.c0 !== 16'hA5A5) begin n_err++; $display("FAIL verbatim_a5: got %h expected a5a5", bus.c0); end
        do_read(0, 7);
    endtask

    task automatic test_gaps();
        send_frame(0, 1'b0, 1'b1, -1, -1);
        do_read(2, 5);
        do_read(0, 3);
        do_read(0, 7);
    endtask

    task automatic test_reset_mid_load();
        do_read(2, 5);
        send_frame(1, 1'b0, 1'b0, 100, -1);
        rst = 1'b1;
        #1;
        n_cmp += 4;
        if (bus.c0 !== 16'h0)         begin n_err++; $display("FAIL async_rst_c0: got %h expected 0000", bus.c0); end
        if (bus.c1 !== 16'h0)         begin n_err++; $display("FAIL async_rst_c1: got %h expected 0000", bus.c1); end
        if (bus.table_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_tv: got %b expected 0", bus.table_valid); end
        if (bus.wr_ready !== 1'b1)    begin n_err++; $display("FAIL async_rst_ready: got %b expected 1", bus.wr_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h11, 1'b0);
        do_read(0, 0);
        do_read(3, 0);
        do_read(3, 1);
        send_frame(0, 1'b0, 1'b0, -1, -1);
        do_read(3, 1);
    endtask

    task automatic test_out_of_range();
        do_read(2, 5);
        do_read(8, 0);
        do_read(2, 6);
        do_read(15, 7);
    endtask

    initial begin
        bus.wr_byte         = 8'h00;
        bus.wr_valid        = 1'b0;
        bus.en              = 1'b0;
        bus.section_addr    = 4'd0;
        bus.subsection_addr = 3'd0;
        test_reset();
        test_full_frame();
        test_bad_checksum();
        test_sync_hunt();
        test_gaps();
        test_reset_mid_load();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
